// File: rtl/uart_host.sv
// UART host: streams a 640-bit header as 80 8N1 bytes, then waits for a 4-byte nonce from the miner.
// Optional nonce-wait timeout is built only when UART_HOST_TIMEOUT_EN is defined.
module uart_host #(
   parameter int CLKS_PER_BIT   = 434,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [639:0] header_in,
   input  logic         start,
   input  logic         rxd,
   output logic         txd,
   output logic         busy,
   output logic [31:0]  nonce_out,
   output logic         nonce_valid,
   output logic         frame_err,
   output logic         timeout
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CHK  = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {IDLE, TX_START, TX_DATA, TX_STOP, WAIT_NONCE} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   tx_state_t     state_q, state_d;
   logic [639:0]  hdr_q, hdr_d;
   logic [CW-1:0] tx_clk_q, tx_clk_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [6:0]    tx_byte_q, tx_byte_d;
   logic [7:0]    tx_cur;

   rx_state_t     rx_state_q, rx_state_d;
   logic [1:0]    rx_sync_q;
   logic          rx_prev_q;
   logic          rx_s;
   logic [CW-1:0] rx_clk_q, rx_clk_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [1:0]    rx_cnt_q, rx_cnt_d;
   logic [23:0]   nonce_acc_q, nonce_acc_d;
   logic [31:0]   nonce_q, nonce_d;
   logic          nonce_valid_q, nonce_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          nonce_done;
   logic          tmo_hit;

   // Two-flop synchronizer; rx_prev_q gives the falling-edge reference.
   assign rx_s = rx_sync_q[1];

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_clk_d      = rx_clk_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_cnt_d      = rx_cnt_q;
      nonce_acc_d   = nonce_acc_q;
      nonce_d       = nonce_q;
      nonce_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      nonce_done    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s && rx_prev_q) begin
               rx_state_d = RX_START;
               rx_clk_d   = '0;
            end
         end
         RX_START: begin
            if (rx_clk_q == HALF_CHK) begin
               rx_clk_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_clk_d = rx_clk_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_clk_q == BIT_LAST) begin
               rx_clk_d   = '0;
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else begin
               rx_clk_d = rx_clk_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_clk_q == BIT_LAST) begin
               rx_clk_d   = '0;
               rx_state_d = RX_IDLE;
               if (!rx_s) begin
                  frame_err_d = 1'b1;
                  rx_cnt_d    = '0;
               end else if (rx_cnt_q == 2'd3) begin
                  nonce_d       = {nonce_acc_q, rx_shift_q};
                  nonce_valid_d = 1'b1;
                  nonce_done    = 1'b1;
                  rx_cnt_d      = '0;
               end else begin
                  nonce_acc_d = {nonce_acc_q[15:0], rx_shift_q};
                  rx_cnt_d    = rx_cnt_q + 1'b1;
               end
            end else begin
               rx_clk_d = rx_clk_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
      if (tmo_hit) rx_cnt_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_sync_q     <= 2'b11;
         rx_prev_q     <= 1'b1;
         rx_state_q    <= RX_IDLE;
         rx_clk_q      <= '0;
         rx_bit_q      <= '0;
         rx_shift_q    <= '0;
         rx_cnt_q      <= '0;
         nonce_acc_q   <= '0;
         nonce_q       <= '0;
         nonce_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         rx_sync_q     <= {rx_sync_q[0], rxd};
         rx_prev_q     <= rx_s;
         rx_state_q    <= rx_state_d;
         rx_clk_q      <= rx_clk_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         rx_cnt_q      <= rx_cnt_d;
         nonce_acc_q   <= nonce_acc_d;
         nonce_q       <= nonce_d;
         nonce_valid_q <= nonce_valid_d;
         frame_err_q   <= frame_err_d;
      end
   end

`ifdef UART_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q;
   logic          timeout_q;

   // A nonce completing on the final wait cycle takes priority over expiry.
   assign tmo_hit = (state_q == WAIT_NONCE) && !nonce_done &&
                    (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= tmo_hit;
         tmo_q     <= (state_q == WAIT_NONCE && !tmo_hit) ? tmo_q + 1'b1 : '0;
      end
   end
   assign timeout = timeout_q;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   assign tx_cur = hdr_q[639:632];

   always_comb begin
      state_d   = state_q;
      hdr_d     = hdr_q;
      tx_clk_d  = tx_clk_q;
      tx_bit_d  = tx_bit_q;
      tx_byte_d = tx_byte_q;
      txd       = 1'b1;
      case (state_q)
         IDLE: begin
            if (start) begin
               hdr_d     = header_in;
               tx_clk_d  = '0;
               tx_bit_d  = '0;
               tx_byte_d = '0;
               state_d   = TX_START;
            end
         end
         TX_START: begin
            txd = 1'b0;
            if (tx_clk_q == BIT_LAST) begin
               tx_clk_d = '0;
               tx_bit_d = '0;
               state_d  = TX_DATA;
            end else begin
               tx_clk_d = tx_clk_q + 1'b1;
            end
         end
         TX_DATA: begin
            txd = tx_cur[tx_bit_q];
            if (tx_clk_q == BIT_LAST) begin
               tx_clk_d = '0;
               if (tx_bit_q == 3'd7) state_d  = TX_STOP;
               else                  tx_bit_d = tx_bit_q + 1'b1;
            end else begin
               tx_clk_d = tx_clk_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_clk_q == BIT_LAST) begin
               tx_clk_d = '0;
               if (tx_byte_q == 7'd79) begin
                  state_d = WAIT_NONCE;
               end else begin
                  tx_byte_d = tx_byte_q + 1'b1;
                  hdr_d     = {hdr_q[631:0], 8'h00};
                  state_d   = TX_START;
               end
            end else begin
               tx_clk_d = tx_clk_q + 1'b1;
            end
         end
         WAIT_NONCE: begin
            if (nonce_done || tmo_hit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         hdr_q     <= '0;
         tx_clk_q  <= '0;
         tx_bit_q  <= '0;
         tx_byte_q <= '0;
      end else begin
         state_q   <= state_d;
         hdr_q     <= hdr_d;
         tx_clk_q  <= tx_clk_d;
         tx_bit_q  <= tx_bit_d;
         tx_byte_q <= tx_byte_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign nonce_out   = nonce_q;
   assign nonce_valid = nonce_valid_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_host.sv
// Directed/randomized bench for uart_host with a bit-stream and byte-queue reference model.
module tb_uart_host;
   localparam int CPB = 4;
   localparam int TMO = 1000;
   localparam int FRAME = 10 * CPB;

   logic         clock = 1'b0;
   logic         reset, start, rxd;
   logic [639:0] header_in;
   logic         txd, busy, nonce_valid, frame_err, timeout;
   logic [31:0]  nonce_out;

   int compared = 0, mismatched = 0;
   int nv_cnt = 0, fe_cnt = 0, to_cnt = 0;

   logic [7:0]  good_q[$];
   logic [31:0] model_nonce = 32'h0;

   uart_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .header_in(header_in), .start(start), .rxd(rxd),
      .txd(txd), .busy(busy), .nonce_out(nonce_out), .nonce_valid(nonce_valid),
      .frame_err(frame_err), .timeout(timeout)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (nonce_valid) nv_cnt <= nv_cnt + 1;
      if (frame_err)   fe_cnt <= fe_cnt + 1;
      if (timeout)     to_cnt <= to_cnt + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic tickn(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [639:0] rand_hdr();
      logic [639:0] r;
      for (int i = 0; i < 20; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Expected txd k cycles after the first start-bit cycle of a header.
   function automatic logic exp_tx(input logic [639:0] h, input int k);
      int f, b;
      logic [7:0] by;
      f  = k / FRAME;
      b  = (k % FRAME) / CPB;
      by = h[639 - 8*f -: 8];
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return by[b-1];
   endfunction

   function automatic logic [9:0] exp_frame0(input logic [639:0] h);
      logic [9:0] f;
      for (int i = 0; i < 10; i++) f[i] = exp_tx(h, i*CPB + 2);
      return f;
   endfunction

   // Pulses start with h, then checks ncyc cycles of txd; a second start at ignore_at must be ignored.
   task automatic run_tx(input logic [639:0] h, input int ncyc, input int ignore_at,
                         output int errs, output int busy_low, output logic [9:0] frame0);
      errs = 0; busy_low = 0; frame0 = '0;
      header_in = h;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         header_in = rand_hdr();
         start = (k == ignore_at);
         if (txd !== exp_tx(h, k)) errs++;
         if (busy !== 1'b1) busy_low++;
         if (k < FRAME && (k % CPB) == 2) frame0[k / CPB] = txd;
         tick();
      end
      start = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      tickn(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tickn(CPB);
      end
      rxd = stop;
      tickn(CPB);
      rxd = 1'b1;
      if (!stop) begin
         good_q.delete();
         tickn(2 * CPB);
      end else begin
         good_q.push_back(b);
         if (good_q.size() == 4) begin
            model_nonce = {good_q[0], good_q[1], good_q[2], good_q[3]};
            good_q.delete();
         end
      end
   endtask

   initial begin
      logic [639:0] h;
      logic [9:0]   fr;
      logic [31:0]  snap;
      int errs, blow, nv0, fe0, to0, npre, first_to;

      reset = 1'b1; start = 1'b0; rxd = 1'b1; header_in = '0;
      tickn(3);
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_nonce", nonce_out, 0);
      chk("rst_nv", nonce_valid, 0);
      chk("rst_fe", frame_err, 0);
      chk("rst_to", timeout, 0);
      reset = 1'b0;
      tick();

      // Full header; a start pulse mid-transfer and header_in churn must not disturb it.
      h = rand_hdr();
      h[639:632] = 8'h01;
      h[7:0]     = 8'h8F;
      run_tx(h, 80 * FRAME, 500, errs, blow, fr);
      chk("tx_stream_errs", errs, 0);
      chk("tx_busy_low", blow, 0);
      chk("tx_frame0", fr, 10'b1000000010);
      chk("wait_txd_idle", txd, 1);
      chk("wait_busy", busy, 1);

      nv0 = nv_cnt;
      rx_byte(8'hDE, 1); rx_byte(8'hAD, 1); rx_byte(8'hBE, 1); rx_byte(8'hEF, 1);
      tickn(12);
      chk("nonce_deadbeef", nonce_out, model_nonce);
      chk("nonce_nv_pulses", nv_cnt - nv0, 1);
      chk("nonce_to_idle", busy, 0);

      nv0 = nv_cnt; fe0 = fe_cnt;
      rx_byte(8'h12, 0);
      rx_byte(8'hDE, 1); rx_byte(8'hAD, 1); rx_byte(8'hBE, 1); rx_byte(8'hEF, 1);
      tickn(12);
      chk("ferr_pulses", fe_cnt - fe0, 1);
      chk("ferr_nonce", nonce_out, model_nonce);
      chk("ferr_nv_pulses", nv_cnt - nv0, 1);

      nv0 = nv_cnt; fe0 = fe_cnt; snap = nonce_out;
      rxd = 1'b0;
      tick();
      rxd = 1'b1;
      tickn(60);
      chk("glitch_nv", nv_cnt - nv0, 0);
      chk("glitch_fe", fe_cnt - fe0, 0);
      chk("glitch_nonce", nonce_out, snap);

      // Partial nonce, then a framing error, then a full nonce: the partial bytes must be dropped.
      for (int it = 0; it < 3; it++) begin
         nv0 = nv_cnt;
         npre = $urandom_range(1, 3);
         for (int j = 0; j < npre; j++) rx_byte(8'($urandom), 1);
         rx_byte(8'($urandom), 0);
         for (int j = 0; j < 4; j++) rx_byte(8'($urandom), 1);
         tickn(12);
         chk("rand_nonce", nonce_out, model_nonce);
         chk("rand_nv_pulses", nv_cnt - nv0, 1);
         chk("rand_idle", busy, 0);
      end

      // Nonce during transmit, then reset at byte 40 bit 3.
      h = rand_hdr();
      header_in = h;
      start = 1'b1;
      tick();
      start = 1'b0;
      nv0 = nv_cnt;
      for (int j = 0; j < 4; j++) rx_byte(8'($urandom), 1);
      tickn(12);
      chk("txrx_nonce", nonce_out, model_nonce);
      chk("txrx_nv_pulses", nv_cnt - nv0, 1);
      chk("txrx_busy", busy, 1);
      tickn(40 * FRAME + 3 * CPB - (4 * FRAME + 12));
      chk("pre_rst_txd", txd, exp_tx(h, 40 * FRAME + 3 * CPB));
      reset = 1'b1;
      tick();
      chk("midrst_txd", txd, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_nonce", nonce_out, 0);
      reset = 1'b0;
      good_q.delete();
      model_nonce = 32'h0;
      tick();

      h = rand_hdr();
      run_tx(h, 80 * FRAME, -1, errs, blow, fr);
      chk("tx2_stream_errs", errs, 0);
      chk("tx2_frame0", fr, exp_frame0(h));

      to0 = to_cnt;
      first_to = -1;
      for (int j = 0; j < TMO + 100; j++) begin
         if (timeout === 1'b1 && first_to < 0) first_to = j;
         if (first_to == j) chk("to_busy_at_pulse", busy, 0);
         tick();
      end
`ifdef UART_HOST_TIMEOUT_EN
      chk("to_at_cycle", 64'(first_to), 64'(TMO));
      chk("to_pulses", to_cnt - to0, 1);
      chk("to_idle", busy, 0);
`else
      chk("noto_pulses", to_cnt - to0, 0);
      chk("noto_busy", busy, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/uart_host.md
UART_HOST -- requirements
Module: uart_host

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal values >= 4.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000000, nonce-wait limit in clocks; used only under REQ-024.
REQ-003 SHALL have port clock  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port header_in  in  640  block header to send; sampled on the start cycle.
REQ-006 SHALL have port start  in  1  one-cycle request to send header_in; honoured only in IDLE.
REQ-007 SHALL have port rxd  in  1  serial input carrying the miner's nonce; idles high.
REQ-008 SHALL have port txd  out  1  serial output carrying the header; idles high.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port nonce_out  out  32  last complete nonce; held until the next one completes.
REQ-011 SHALL have port nonce_valid  out  1  one-cycle pulse when nonce_out updates.
REQ-012 SHALL have port frame_err  out  1  one-cycle pulse on a received stop bit sampled low.
REQ-013 SHALL have port timeout  out  1  one-cycle pulse on nonce-wait expiry (REQ-024).

Function
REQ-014 SHALL frame each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT clocks.
REQ-015 SHALL send the header as 80 back-to-back bytes, header_in[639:632] first and header_in[7:0] last, with no idle gap between the stop bit and the next start bit.
REQ-016 SHALL run the FSM IDLE -> TX_START -> TX_DATA -> TX_STOP, returning to TX_START while bytes remain and going to WAIT_NONCE after byte 80; WAIT_NONCE -> IDLE when a nonce completes.
REQ-017 SHALL capture header_in into an internal register on the start cycle; txd SHALL go low on the following cycle; later changes to header_in SHALL NOT affect the transfer.
REQ-018 SHALL ignore start while busy is high.
REQ-019 SHALL run the receiver independently of the FSM at all times: detect the rxd falling edge, re-check rxd low at CLKS_PER_BIT/2, and abort silently to receiver idle if rxd is high.
REQ-020 SHALL sample each data bit at the centre of its bit period, then the stop bit at its centre.
REQ-021 SHALL discard a byte whose stop bit is low, pulse frame_err, and reset the nonce byte counter to 0.
REQ-022 SHALL assemble nonce_out MSB byte first: the first received byte goes to nonce_out[31:24]. The fourth good byte SHALL update nonce_out and pulse nonce_valid one cycle after its stop-bit sample, then wrap the byte counter to 0.
REQ-023 SHALL accept a nonce arriving during IDLE or TX_* states: it updates nonce_out and pulses nonce_valid, with no FSM state change.

Configuration
REQ-024 With UART_HOST_TIMEOUT_EN defined, SHALL count clocks in WAIT_NONCE and, on reaching TIMEOUT_CYCLES without a nonce completing, pulse timeout, clear the receiver byte counter and go to IDLE. Without the macro, WAIT_NONCE SHALL wait indefinitely, timeout SHALL be constant 0, and no counter logic SHALL be built.

Reset
REQ-025 While reset is high, txd = 1, busy = 0, nonce_out = 0, nonce_valid = 0, frame_err = 0, timeout = 0, FSM = IDLE, receiver idle, and all counters = 0.
REQ-026 Reset asserted mid-transfer SHALL abort at once: txd is high on the cycle after reset, and any partial byte is discarded.

Verification (CLKS_PER_BIT = 4, TIMEOUT_CYCLES = 1000)
REQ-027 Send header_in with byte 0 = 8'h01 and byte 79 = 8'h8F, start pulsed for one cycle -> txd shows 80 frames of 40 clocks each (3200 clocks total); first frame bits 0,1,0,0,0,0,0,0,0,1; busy high throughout.
REQ-028 Drive rxd with bytes 8'hDE, 8'hAD, 8'hBE, 8'hEF in WAIT_NONCE -> nonce_out = 32'hDEADBEEF, one nonce_valid pulse, FSM returns to IDLE, busy = 0.
REQ-029 Send byte 8'h12 with a low stop bit, then 8'hDE, 8'hAD, 8'hBE, 8'hEF -> one frame_err pulse, nonce_out = 32'hDEADBEEF.
REQ-030 Drive a 1-clock low glitch on rxd -> no byte received, no pulses.
REQ-031 Assert reset at transmitted byte 40, bit 3 -> txd high on the next cycle, busy = 0; a new start then sends byte 0 first.
REQ-032 With UART_HOST_TIMEOUT_EN defined, keep rxd idle after the header -> timeout pulses exactly 1000 clocks after WAIT_NONCE entry and the FSM returns to IDLE; without the macro, busy stays high.
